// File: rtl/pipe_ctrl.sv
// pipe_ctrl: run/step/halt sequencer and fetch-side hazard control for a six-stage pipeline.
//
// Ports
//   clk              sole clock, rising edge
//   rst              asynchronous active-low reset
//   run_i            level, request continuous execution
//   step_i           level, request a single instruction
//   halt_i           level, request stop (highest priority)
//   stallreq_id_i    ID operand-hazard stall request
//   stallreq_ex_i    EX multi-cycle stall request (dominates ID)
//   branch_i         taken branch resolved in ID, held by source until accepted
//   branch_target_i  branch destination
//   pc_o             registered fetch address
//   ce_o             fetch enable, combinational from state and halt_i
//   stall_o          per-stage hold [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
//   flush_o          registered one-cycle pulse, IF/ID loads a bubble
//   state_o          00 IDLE, 01 RUN, 10 STEP, 11 HALT
//   fetch_cnt_o      registered count of advancing fetches
module pipe_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run_i,
   input  logic        step_i,
   input  logic        halt_i,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic        branch_i,
   input  logic [15:0] branch_target_i,
   output logic [15:0] pc_o,
   output logic        ce_o,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [1:0]  state_o,
   output logic [15:0] fetch_cnt_o
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StStep = 2'b10,
      StHalt = 2'b11
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] cnt_q, cnt_d;
   logic        flush_q, flush_d;
   logic        ce;
   logic [5:0]  stall;
   logic        advance;

   // Fetch enable and stall vector. While not fetching only PC and IF/ID are
   // held so the downstream stages keep draining.
   always_comb begin
      ce = 1'b0;
      if ((state_q == StRun || state_q == StStep) && !halt_i) begin
         ce = 1'b1;
      end
      if (!ce) begin
         stall = 6'b000011;
      end else if (stallreq_ex_i) begin
         stall = 6'b001111;
      end else if (stallreq_id_i) begin
         stall = 6'b000111;
      end else begin
         stall = 6'b000000;
      end
      advance = ce & ~stall[0];
   end

   // Next state; halt_i > step_i > run_i everywhere.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StHalt: begin
            if (halt_i) begin
               state_d = StHalt;
            end else if (step_i) begin
               state_d = StStep;
            end else if (run_i) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (halt_i) begin
               state_d = StHalt;
            end
         end
         StStep: begin
            // One advancing fetch, then park in HALT.
            if (halt_i || advance) begin
               state_d = StHalt;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next values; branch_i only matters on an advancing cycle.
   always_comb begin
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      flush_d = 1'b0;
      if (advance) begin
         cnt_d = cnt_q + 16'd1;
         if (branch_i) begin
            pc_d    = branch_target_i;
            flush_d = 1'b1;
         end else begin
            pc_d = pc_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         cnt_q   <= 16'h0000;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
      end
   end

   assign pc_o        = pc_q;
   assign ce_o        = ce;
   assign stall_o     = stall;
   assign flush_o     = flush_q;
   assign state_o     = state_q;
   assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl. The driver applies inputs #1 after each rising edge
// and pushes the hand-computed outputs expected for that cycle; the monitor pops and compares
// on the falling edge. A second instance with RESET_PC=16'hFFFE covers PC wrap.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        run, step, halt, sid, sex, br;
   logic [15:0] tgt;
   logic        run1, halt1;

   logic [15:0] pc0, cnt0, pc1, cnt1;
   logic        ce0, fl0, ce1, fl1;
   logic [5:0]  stall0, stall1;
   logic [1:0]  st0, st1;

   int cyc   = 0;
   int nvec  = 0;
   int nfail = 0;

   typedef struct {
      int          cyc;
      bit          which;
      logic [1:0]  st;
      logic [15:0] pc;
      logic [15:0] cnt;
      logic        fl;
      logic        ce;
      logic [5:0]  stall;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   pipe_ctrl dut0 (
      .clk(clk), .rst(rst), .run_i(run), .step_i(step), .halt_i(halt),
      .stallreq_id_i(sid), .stallreq_ex_i(sex), .branch_i(br), .branch_target_i(tgt),
      .pc_o(pc0), .ce_o(ce0), .stall_o(stall0), .flush_o(fl0), .state_o(st0),
      .fetch_cnt_o(cnt0)
   );

   pipe_ctrl #(.RESET_PC(16'hFFFE)) dut1 (
      .clk(clk), .rst(rst), .run_i(run1), .step_i(1'b0), .halt_i(halt1),
      .stallreq_id_i(1'b0), .stallreq_ex_i(1'b0), .branch_i(1'b0),
      .branch_target_i(16'h0000),
      .pc_o(pc1), .ce_o(ce1), .stall_o(stall1), .flush_o(fl1), .state_o(st1),
      .fetch_cnt_o(cnt1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int c, input bit w,
                      input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s cyc%0d dut%0d: got %h want %h", nm, c, w, act, exp);
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.which == 1'b0) begin
            chk("state", mon_e.cyc, 0, {14'd0, st0}, {14'd0, mon_e.st});
            chk("pc", mon_e.cyc, 0, pc0, mon_e.pc);
            chk("cnt", mon_e.cyc, 0, cnt0, mon_e.cnt);
            chk("flush", mon_e.cyc, 0, {15'd0, fl0}, {15'd0, mon_e.fl});
            chk("ce", mon_e.cyc, 0, {15'd0, ce0}, {15'd0, mon_e.ce});
            chk("stall", mon_e.cyc, 0, {10'd0, stall0}, {10'd0, mon_e.stall});
         end else begin
            chk("state", mon_e.cyc, 1, {14'd0, st1}, {14'd0, mon_e.st});
            chk("pc", mon_e.cyc, 1, pc1, mon_e.pc);
            chk("cnt", mon_e.cyc, 1, cnt1, mon_e.cnt);
            chk("flush", mon_e.cyc, 1, {15'd0, fl1}, {15'd0, mon_e.fl});
            chk("ce", mon_e.cyc, 1, {15'd0, ce1}, {15'd0, mon_e.ce});
            chk("stall", mon_e.cyc, 1, {10'd0, stall1}, {10'd0, mon_e.stall});
         end
      end
   end

   task automatic push(input bit w, input logic [1:0] e_st, input logic [15:0] e_pc,
                       input logic [15:0] e_cnt, input bit e_fl, input bit e_ce,
                       input logic [5:0] e_stall);
      exp_t e;
      e.cyc = cyc; e.which = w; e.st = e_st; e.pc = e_pc; e.cnt = e_cnt;
      e.fl = e_fl; e.ce = e_ce; e.stall = e_stall;
      sb.push_back(e);
   endtask

   // Inputs for dut0, then the outputs expected at the falling edge of this same cycle.
   task automatic vec(input bit r, input bit ru, input bit sp, input bit ha, input bit id,
                      input bit ex, input bit b, input logic [15:0] t,
                      input logic [1:0] e_st, input logic [15:0] e_pc, input logic [15:0] e_cnt,
                      input bit e_fl, input bit e_ce, input logic [5:0] e_stall);
      @(posedge clk);
      #1;
      rst = r; run = ru; step = sp; halt = ha; sid = id; sex = ex; br = b; tgt = t;
      push(0, e_st, e_pc, e_cnt, e_fl, e_ce, e_stall);
   endtask

   task automatic vec1(input bit ru, input bit ha, input logic [1:0] e_st,
                       input logic [15:0] e_pc, input logic [15:0] e_cnt, input bit e_ce,
                       input logic [5:0] e_stall);
      @(posedge clk);
      #1;
      run1 = ru; halt1 = ha;
      push(1, e_st, e_pc, e_cnt, 1'b0, e_ce, e_stall);
   endtask

   initial begin
      rst = 1'b0;
      run = 0; step = 0; halt = 0; sid = 0; sex = 0; br = 0; tgt = 16'h0000;
      run1 = 0; halt1 = 0;

      // Reset state, both instances
      vec(0, 0,0,0,0,0,0, 16'h0, 2'b00, 16'h0000, 16'h0, 0, 0, 6'b000011);
      push(1, 2'b00, 16'hFFFE, 16'h0, 0, 0, 6'b000011);

      // Release, run: IDLE -> RUN, pc 0..4
      vec(1, 1,0,0,0,0,0, 16'h0, 2'b00, 16'h0000, 16'h0, 0, 0, 6'b000011);
      vec(1, 1,0,0,0,0,0, 16'h0, 2'b01, 16'h0000, 16'h0, 0, 1, 6'b000000);
      vec(1, 1,0,0,0,0,0, 16'h0, 2'b01, 16'h0001, 16'h1, 0, 1, 6'b000000);
      vec(1, 1,0,0,0,0,0, 16'h0, 2'b01, 16'h0002, 16'h2, 0, 1, 6'b000000);
      vec(1, 1,0,0,0,0,0, 16'h0, 2'b01, 16'h0003, 16'h3, 0, 1, 6'b000000);
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b01, 16'h0004, 16'h4, 0, 1, 6'b000000);
      // ID stall x2, EX stall x1 at pc 5
      vec(1, 0,0,0,1,0,0, 16'h0, 2'b01, 16'h0005, 16'h5, 0, 1, 6'b000111);
      vec(1, 0,0,0,1,0,0, 16'h0, 2'b01, 16'h0005, 16'h5, 0, 1, 6'b000111);
      vec(1, 0,0,0,1,1,0, 16'h0, 2'b01, 16'h0005, 16'h5, 0, 1, 6'b001111);
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b01, 16'h0005, 16'h5, 0, 1, 6'b000000);
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b01, 16'h0006, 16'h6, 0, 1, 6'b000000);
      // Taken branch at pc 7, flush one cycle
      vec(1, 0,0,0,0,0,1, 16'h0040, 2'b01, 16'h0007, 16'h7, 0, 1, 6'b000000);
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b01, 16'h0040, 16'h8, 1, 1, 6'b000000);
      // Branch during stall is ignored
      vec(1, 0,0,0,1,0,1, 16'h1234, 2'b01, 16'h0041, 16'h9, 0, 1, 6'b000111);
      // Halt from RUN
      vec(1, 0,0,1,0,0,0, 16'h0, 2'b01, 16'h0041, 16'h9, 0, 0, 6'b000011);
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b11, 16'h0041, 16'h9, 0, 0, 6'b000011);
      // Step held by EX stall, then one advance, back to HALT
      vec(1, 0,1,0,0,1,0, 16'h0, 2'b11, 16'h0041, 16'h9, 0, 0, 6'b000011);
      vec(1, 0,0,0,0,1,0, 16'h0, 2'b10, 16'h0041, 16'h9, 0, 1, 6'b001111);
      vec(1, 0,0,0,0,1,0, 16'h0, 2'b10, 16'h0041, 16'h9, 0, 1, 6'b001111);
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b10, 16'h0041, 16'h9, 0, 1, 6'b000000);
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b11, 16'h0042, 16'hA, 0, 0, 6'b000011);
      // Halt wins over step inside STEP, no fetch
      vec(1, 0,1,0,0,0,0, 16'h0, 2'b11, 16'h0042, 16'hA, 0, 0, 6'b000011);
      vec(1, 0,1,1,0,0,0, 16'h0, 2'b10, 16'h0042, 16'hA, 0, 0, 6'b000011);
      // Resume RUN from held pc; step ignored in RUN
      vec(1, 1,0,0,0,0,0, 16'h0, 2'b11, 16'h0042, 16'hA, 0, 0, 6'b000011);
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b01, 16'h0042, 16'hA, 0, 1, 6'b000000);
      vec(1, 0,1,0,0,0,0, 16'h0, 2'b01, 16'h0043, 16'hB, 0, 1, 6'b000000);
      // All requests together -> HALT, priority held in HALT
      vec(1, 1,1,1,0,0,0, 16'h0, 2'b01, 16'h0044, 16'hC, 0, 0, 6'b000011);
      vec(1, 1,0,1,0,0,0, 16'h0, 2'b11, 16'h0044, 16'hC, 0, 0, 6'b000011);
      vec(1, 1,0,0,0,0,0, 16'h0, 2'b11, 16'h0044, 16'hC, 0, 0, 6'b000011);
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b01, 16'h0044, 16'hC, 0, 1, 6'b000000);

      // Asynchronous reset between edges during RUN
      @(posedge clk);
      #1;
      run = 1; step = 0; halt = 0; sid = 0; sex = 0; br = 0;
      #1;
      rst = 1'b0;
      push(0, 2'b00, 16'h0000, 16'h0, 0, 0, 6'b000011);
      push(1, 2'b00, 16'hFFFE, 16'h0, 0, 0, 6'b000011);
      vec(0, 1,0,0,0,0,0, 16'h0, 2'b00, 16'h0000, 16'h0, 0, 0, 6'b000011);
      // Release does not start execution
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b00, 16'h0000, 16'h0, 0, 0, 6'b000011);
      vec(1, 0,0,0,0,0,0, 16'h0, 2'b00, 16'h0000, 16'h0, 0, 0, 6'b000011);

      // RESET_PC=FFFE instance: PC wraps, halt beats run
      vec1(1, 0, 2'b00, 16'hFFFE, 16'h0, 0, 6'b000011);
      vec1(0, 0, 2'b01, 16'hFFFE, 16'h0, 1, 6'b000000);
      vec1(0, 0, 2'b01, 16'hFFFF, 16'h1, 1, 6'b000000);
      vec1(0, 0, 2'b01, 16'h0000, 16'h2, 1, 6'b000000);
      vec1(1, 1, 2'b01, 16'h0001, 16'h3, 0, 6'b000011);
      vec1(0, 0, 2'b11, 16'h0001, 16'h3, 0, 6'b000011);

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      nvec++;
      if (sb.size() != 0) begin
         nfail++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
